// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 BCM scan controller.
//   state_t   - scan FSM states
//   RGB_*     - bit positions of {R1,G1,B1,R2,G2,B2} within the 6-bit colour word
//   DISP_W    - width of the display-time down-counter
//   bcm_load  - display ticks for a bitplane (base << plane)
package hub75_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DRIVE,
      ST_CLKHI,
      ST_BLANK,
      ST_LATCH,
      ST_UNLATCH,
      ST_DISPLAY
   } state_t;

   localparam int RGB_R1 = 5;
   localparam int RGB_G1 = 4;
   localparam int RGB_B1 = 3;
   localparam int RGB_R2 = 2;
   localparam int RGB_G2 = 1;
   localparam int RGB_B2 = 0;

   localparam int DISP_W = 16;

   function automatic logic [DISP_W-1:0] bcm_load(input int base, input logic [2:0] plane);
      return DISP_W'(base) << plane;
   endfunction

endpackage

// File: rtl/bcm_timer.sv
// bcm_timer: display-time down-counter for one bitplane.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_tick        pixel-rate enable; the counter only moves on tick
//   i_load        load BASE_OE_TICKS<<i_plane (on tick)
//   i_en          count down (on tick) while the plane is being displayed
//   i_plane       bitplane selecting the load value
//   o_done        last display tick of the plane (disp==1 on a tick while enabled)
module bcm_timer
   import hub75_pkg::*;
#(
   parameter int BASE_OE_TICKS = 8
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [2:0] i_plane,
   output logic       o_done
);

   logic [DISP_W-1:0] r_disp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_disp <= '0;
      end else if (i_tick) begin
         if (i_load)
            r_disp <= bcm_load(BASE_OE_TICKS, i_plane);
         else if (i_en && (r_disp != '0))
            r_disp <= r_disp - DISP_W'(1);
      end
   end

   assign o_done = i_tick && i_en && (r_disp == DISP_W'(1));

endmodule

// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: HUB75 scan controller with binary-code modulation.
// For every row pair and every bitplane: fetch COLS pixel pairs from the
// frame buffer, shift them out, latch, then hold OE low for BASE_OE_TICKS<<plane ticks.
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_tick                pixel-rate enable; all sequencing advances only on tick
//   i_enable              scan continuously; when low, stop at the next frame boundary
//   o_px_req              frame-buffer read strobe (one tick period)
//   o_px_row/col/plane    address of the requested pixel pair
//   i_px_rgb              {R1,G1,B1,R2,G2,B2}, valid on the tick after o_px_req
//   o_h75_*               HUB75 pins (colour, Clk, Lat, OE active low, A..E)
//   o_busy                high when not idle
//   o_frame_done          one-clock pulse after the last plane of the last row
module hub75_bcm_scheduler
   import hub75_pkg::*;
#(
   parameter int COLS          = 64,
   parameter int ROW_BITS      = 5,
   parameter int BITPLANES     = 4,
   parameter int BASE_OE_TICKS = 8
)(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_tick,
   input  logic                i_enable,
   output logic                o_px_req,
   output logic [ROW_BITS-1:0] o_px_row,
   output logic [5:0]          o_px_col,
   output logic [2:0]          o_px_plane,
   input  logic [5:0]          i_px_rgb,
   output logic                o_h75_r1,
   output logic                o_h75_g1,
   output logic                o_h75_b1,
   output logic                o_h75_r2,
   output logic                o_h75_g2,
   output logic                o_h75_b2,
   output logic                o_h75_clk,
   output logic                o_h75_lat,
   output logic                o_h75_oe,
   output logic                o_h75_a,
   output logic                o_h75_b,
   output logic                o_h75_c,
   output logic                o_h75_d,
   output logic                o_h75_e,
   output logic                o_busy,
   output logic                o_frame_done
);

   localparam logic [5:0] LP_LAST_COL   = 6'(COLS - 1);
   localparam logic [2:0] LP_LAST_PLANE = 3'(BITPLANES - 1);

   state_t              r_state, w_next;
   logic [ROW_BITS-1:0] r_row;
   logic [5:0]          r_col;
   logic [2:0]          r_plane;

   logic       r_px_req, r_clk, r_lat, r_oe, r_busy, r_frame_done;
   logic [5:0] r_rgb;
   logic [4:0] r_addr;

   logic w_last_col, w_last_plane, w_last_row;
   logic w_disp_done, w_frame_end;

   assign w_last_col   = (r_col == LP_LAST_COL);
   assign w_last_plane = (r_plane == LP_LAST_PLANE);
   assign w_last_row   = &r_row;
   assign w_frame_end  = (r_state == ST_DISPLAY) && w_disp_done && w_last_plane && w_last_row;

   bcm_timer #(
      .BASE_OE_TICKS (BASE_OE_TICKS)
   ) u_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_tick  (i_tick),
      .i_load  (r_state == ST_UNLATCH),
      .i_en    (r_state == ST_DISPLAY),
      .i_plane (r_plane),
      .o_done  (w_disp_done)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (i_tick) begin
         case (r_state)
            ST_IDLE:    if (i_enable) w_next = ST_FETCH;
            ST_FETCH:   w_next = ST_DRIVE;
            ST_DRIVE:   w_next = ST_CLKHI;
            ST_CLKHI:   w_next = w_last_col ? ST_BLANK : ST_FETCH;
            ST_BLANK:   w_next = ST_LATCH;
            ST_LATCH:   w_next = ST_UNLATCH;
            ST_UNLATCH: w_next = ST_DISPLAY;
            ST_DISPLAY: begin
               if (w_disp_done) begin
                  if (!w_last_plane || !w_last_row) w_next = ST_FETCH;
                  else                              w_next = i_enable ? ST_FETCH : ST_IDLE;
               end
            end
            default:    w_next = ST_IDLE;
         endcase
      end
   end

   // Scan position counters
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_row   <= '0;
         r_col   <= '0;
         r_plane <= '0;
      end else if (i_tick) begin
         case (r_state)
            ST_IDLE: begin
               if (i_enable) begin
                  r_row   <= '0;
                  r_col   <= '0;
                  r_plane <= '0;
               end
            end
            ST_CLKHI: begin
               if (!w_last_col) r_col <= r_col + 6'd1;
            end
            ST_DISPLAY: begin
               if (w_disp_done) begin
                  r_col <= '0;
                  if (!w_last_plane) begin
                     r_plane <= r_plane + 3'd1;
                  end else begin
                     r_plane <= '0;
                     r_row   <= w_last_row ? '0 : r_row + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Pin registers are decoded from the state being entered, so every pin
   // is a clean flop output aligned with the state it belongs to.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_px_req     <= 1'b0;
         r_clk        <= 1'b0;
         r_lat        <= 1'b0;
         r_oe         <= 1'b1;
         r_busy       <= 1'b0;
         r_rgb        <= '0;
         r_addr       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (i_tick) begin
            r_px_req <= (w_next == ST_FETCH);
            r_clk    <= (w_next == ST_CLKHI);
            r_lat    <= (w_next == ST_LATCH);
            r_oe     <= (w_next != ST_DISPLAY);
            r_busy   <= (w_next != ST_IDLE);
            // Frame-buffer data arrives one tick after the request.
            if (r_state == ST_DRIVE) r_rgb <= i_px_rgb;
            // Address moves on entry to LATCH, where OE is guaranteed high.
            if (r_state == ST_BLANK) r_addr <= 5'(r_row);
            if (w_frame_end) r_frame_done <= 1'b1;
         end
      end
   end

   assign o_px_req     = r_px_req;
   assign o_px_row     = r_row;
   assign o_px_col     = r_col;
   assign o_px_plane   = r_plane;
   assign o_h75_r1     = r_rgb[RGB_R1];
   assign o_h75_g1     = r_rgb[RGB_G1];
   assign o_h75_b1     = r_rgb[RGB_B1];
   assign o_h75_r2     = r_rgb[RGB_R2];
   assign o_h75_g2     = r_rgb[RGB_G2];
   assign o_h75_b2     = r_rgb[RGB_B2];
   assign o_h75_clk    = r_clk;
   assign o_h75_lat    = r_lat;
   assign o_h75_oe     = r_oe;
   assign o_h75_a      = r_addr[0];
   assign o_h75_b      = r_addr[1];
   assign o_h75_c      = r_addr[2];
   assign o_h75_d      = r_addr[3];
   assign o_h75_e      = r_addr[4];
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Testbench for hub75_bcm_scheduler (COLS=4, ROW_BITS=1, BITPLANES=2, BASE_OE_TICKS=2,
// tick every second clock). A frame-buffer model answers pixel requests; a
// monitor checks request order, shifted colour, OE-low runs, latch/address
// behaviour and frame length against values computed from the scan rules.
module tb_hub75_bcm_scheduler;

   localparam int COLS  = 4;
   localparam int RB    = 1;
   localparam int BP    = 2;
   localparam int BASE  = 2;
   localparam int ROWS  = 1 << RB;
   localparam int FRAME_REQ   = COLS * BP * ROWS;
   localparam int FRAME_TICKS = ROWS * (BP * (3 * COLS + 3) + BASE * ((1 << BP) - 1));

   logic clk = 0, rst = 1, tick = 0, enable = 0;
   logic px_req, h_clk, lat, oe, busy, frame_done;
   logic [RB-1:0] px_row;
   logic [5:0] px_col, px_rgb = '0;
   logic [2:0] px_plane;
   logic r1, g1, b1, r2, g2, b2, a, b, c, d, e;
   logic [5:0] w_rgb;
   logic [4:0] w_addr;

   assign w_rgb  = {r1, g1, b1, r2, g2, b2};
   assign w_addr = {e, d, c, b, a};

   always #5 clk = ~clk;

   hub75_bcm_scheduler #(.COLS(COLS), .ROW_BITS(RB), .BITPLANES(BP), .BASE_OE_TICKS(BASE)) dut (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_enable(enable),
      .o_px_req(px_req), .o_px_row(px_row), .o_px_col(px_col), .o_px_plane(px_plane),
      .i_px_rgb(px_rgb),
      .o_h75_r1(r1), .o_h75_g1(g1), .o_h75_b1(b1), .o_h75_r2(r2), .o_h75_g2(g2), .o_h75_b2(b2),
      .o_h75_clk(h_clk), .o_h75_lat(lat), .o_h75_oe(oe),
      .o_h75_a(a), .o_h75_b(b), .o_h75_c(c), .o_h75_d(d), .o_h75_e(e),
      .o_busy(busy), .o_frame_done(frame_done)
   );

   int n_asserts = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] model_rgb(input int row, input int col, input int plane);
      logic [31:0] rv, cv, pv;
      rv = row; cv = col; pv = plane;
      return {rv[0], cv[1:0], pv[0], 2'b01};
   endfunction

   // ---------------- tick generator + frame-buffer model ----------------
   logic tick_run = 0;
   logic s_tick = 0, s_req = 0;
   logic [RB-1:0] s_row = '0;
   logic [5:0] s_col = '0;
   logic [2:0] s_plane = '0;

   initial forever begin
      @(posedge clk);
      #1;
      if (s_tick) px_rgb = s_req ? model_rgb(int'(s_row), int'(s_col), int'(s_plane)) : 6'($urandom);
      tick = tick_run ? !tick : 1'b0;
   end

   // ---------------- monitor ----------------
   int k = 0, total_req = 0, rises_f = 0, rises_p = 0, run = 0, j = 0, l = 0;
   int tcnt = 0, n_frames = 0;
   bit have_prev = 0;
   logic prev_clk = 0, prev_lat = 0;
   logic [4:0] prev_addr = '0;
   logic [5:0] exp_q[$];

   initial forever begin
      @(negedge clk);
      s_tick = tick; s_req = px_req; s_row = px_row; s_col = px_col; s_plane = px_plane;
      if (rst) begin
         k = 0; rises_f = 0; rises_p = 0; run = 0; j = 0; l = 0; tcnt = 0;
         have_prev = 0; exp_q.delete();
         prev_clk = 0; prev_lat = 0; prev_addr = '0;
      end else begin
         if (!busy || !enable) have_prev = 0;
         if (tick) tcnt++;
         if (tick && px_req) begin
            int er, ec, ep;
            logic [9:0] ev;
            er = (k / (COLS * BP)) % ROWS;
            ep = (k / COLS) % BP;
            ec = k % COLS;
            ev = {1'(er), 6'(ec), 3'(ep)};
            chk("req_addr", {px_row, px_col, px_plane}, ev);
            exp_q.push_back(model_rgb(er, ec, ep));
            k++; total_req++;
         end
         if (h_clk && !prev_clk) begin
            rises_f++; rises_p++;
            chk("rgb_pending", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("rgb_at_clk", w_rgb, exp_q.pop_front());
         end
         if (tick) begin
            if (!oe) run++;
            else if (run > 0) begin
               chk("oe_low_ticks", run, BASE << (j % BP));
               j++; run = 0;
            end
         end
         if (w_addr != prev_addr) chk("addr_change_oe", oe, 1);
         if (lat) chk("lat_oe", oe, 1);
         if (lat && !prev_lat) begin
            chk("addr_at_latch", w_addr, (l / BP) % ROWS);
            chk("rises_per_plane", rises_p, COLS);
            rises_p = 0; l++;
         end
         if (frame_done) begin
            chk("req_per_frame", k, FRAME_REQ);
            chk("rises_per_frame", rises_f, FRAME_REQ);
            if (have_prev) chk("ticks_per_frame", tcnt, FRAME_TICKS);
            have_prev = 1; tcnt = 0; k = 0; rises_f = 0; n_frames++;
         end
         prev_clk = h_clk; prev_lat = lat; prev_addr = w_addr;
      end
   end

   // ---------------- directed sequence ----------------
   task automatic wait_frames(input int n);
      int target, budget;
      target = n_frames + n;
      budget = n * FRAME_TICKS * 4 + 400;
      while (n_frames < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("wait_frame", n_frames, target);
   endtask

   initial begin
      int budget, skip, ek;
      logic [9:0] ev;

      // 1: reset and idle
      repeat (4) @(negedge clk);
      chk("rst_ctl", {oe, h_clk, lat, busy, px_req, frame_done}, 6'b100000);
      chk("rst_rgb", w_rgb, 0);
      chk("rst_addr", w_addr, 0);
      rst = 0; tick_run = 1;
      repeat (100) begin
         @(negedge clk);
         chk("idle_ctl", {oe, h_clk, lat, busy}, 4'b1000);
      end
      chk("idle_no_req", total_req, 0);

      // 2-4: continuous scan, checked by the monitor
      enable = 1;
      wait_frames(3);

      // 5: drop enable partway through row 0
      skip = $urandom_range(2, 30);
      while (skip > 0) begin
         @(negedge clk);
         if (tick) skip--;
      end
      chk("drop_in_row0", px_row, 0);
      enable = 0;
      wait_frames(1);
      repeat (2) @(negedge clk);
      chk("stopped_idle", {busy, oe}, 2'b01);
      repeat (40) @(negedge clk);
      chk("req_total", total_req, 4 * FRAME_REQ);
      chk("stopped_busy", busy, 0);
      enable = 1;
      wait_frames(1);

      // 6a: reset while OE is low
      budget = 400;
      while (oe !== 1'b0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("wait_oe_low", oe, 0);
      rst = 1;
      @(posedge clk);
      #1;
      chk("rst_in_display", {oe, lat, busy, h_clk}, 4'b1000);
      chk("rst_in_display_addr", w_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 0;

      // 6b: freeze tick during a random CLKHI
      skip = $urandom_range(0, 6);
      budget = 2000;
      while (budget > 0) begin
         @(negedge clk);
         budget--;
         if (h_clk && !tick) begin
            if (skip == 0) break;
            skip--;
         end
      end
      chk("wait_clkhi", {h_clk, tick}, 2'b10);
      tick_run = 0;
      ek = k - 1;
      ev = {1'((ek / (COLS * BP)) % ROWS), 6'(ek % COLS), 3'((ek / COLS) % BP)};
      repeat (50) begin
         @(negedge clk);
         chk("stall_ctl", {h_clk, oe, lat, px_req, busy}, 5'b11001);
         chk("stall_pos", {px_row, px_col, px_plane}, ev);
      end
      tick_run = 1;
      wait_frames(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
